// File: rtl/avalon_ram_pkg.sv
// rtl/avalon_ram_pkg.sv - shared types and constants for the Avalon RAM slave and its stall logic
package avalon_ram_pkg;

   typedef logic [31:0] size_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } avalon_ram_state_t;

   localparam logic [15:0] RAM_LFSR_SEED = 16'hACE1;
   localparam int unsigned WAIT_CNT_W    = 4;

   // Fibonacci form, taps 16,14,13,11.
   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
   endfunction

endpackage

// File: rtl/avalon_ram_wait_gen.sv
// rtl/avalon_ram_wait_gen.sv - wait-state counter; AVALON_RAM_RANDOM_WAIT_EN selects LFSR-driven wait counts
module avalon_ram_wait_gen
   import avalon_ram_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  load_i,
   input  logic                  dec_i,
   output logic [WAIT_CNT_W-1:0] wait_cnt_o,
   output logic                  expired_o
);

   logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

`ifdef AVALON_RAM_RANDOM_WAIT_EN
   logic [15:0] lfsr_q, lfsr_d;

   // The access being accepted uses the current value; the LFSR then steps.
   assign wait_cnt_o = {1'b0, lfsr_q[2:0]};

   always_comb begin
      lfsr_d = lfsr_q;
      if (load_i) lfsr_d = lfsr_next(lfsr_q);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) lfsr_q <= RAM_LFSR_SEED;
      else         lfsr_q <= lfsr_d;
   end
`else
   assign wait_cnt_o = WAIT_CNT_W'(WAIT_CYCLES);
`endif

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)                     cnt_d = wait_cnt_o;
      else if (dec_i && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign expired_o = (cnt_q <= WAIT_CNT_W'(1));

endmodule

// File: rtl/avalon_ram.sv
// rtl/avalon_ram.sv - Avalon-MM word RAM slave with wait states; AVALON_RAM_RANDOM_WAIT_EN randomizes waits
module avalon_ram
   import avalon_ram_pkg::*;
#(
   parameter size_t       BASE_ADDR   = 32'hBFC00000,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter string       INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   output logic        waitrequest,
   output logic [31:0] readdata,
   output logic        err
);

   localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   avalon_ram_state_t state_q, state_d;
   size_t             addr_q, addr_d;
   size_t             wdata_q, wdata_d;
   logic [3:0]        be_q, be_d;
   logic              we_q, we_d;
   logic              err_q, err_d;
   size_t             rdata_q;
   size_t             mem_q [DEPTH_WORDS];

   size_t                 acc_addr;
   size_t                 word_idx;
   logic                  in_range;
   logic [IW-1:0]         mem_idx;
   logic                  load, dec, rd_load, commit;
   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic                  expired;

   // Decode the live bus address when accepting, the latched one afterwards.
   assign acc_addr = (state_q == IDLE) ? address : addr_q;
   assign word_idx = (acc_addr - BASE_ADDR) >> 2;
   assign in_range = (word_idx < DEPTH_WORDS);
   assign mem_idx  = word_idx[IW-1:0];

   avalon_ram_wait_gen #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_wait_gen (
      .clk_i      (clk),
      .rst_ni     (reset),
      .load_i     (load),
      .dec_i      (dec),
      .wait_cnt_o (wait_cnt),
      .expired_o  (expired)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      we_d    = we_q;
      err_d   = err_q;
      load    = 1'b0;
      dec     = 1'b0;
      rd_load = 1'b0;
      case (state_q)
         IDLE: begin
            if (read && write) begin
               err_d = 1'b1;
            end else if (read || write) begin
               addr_d  = address;
               wdata_d = writedata;
               be_d    = byteenable;
               we_d    = write;
               load    = 1'b1;
               if (!in_range || address[1:0] != 2'b00) err_d = 1'b1;
               if (wait_cnt != '0) begin
                  state_d = WAIT;
               end else begin
                  state_d = DONE;
                  rd_load = 1'b1;
               end
            end
         end
         WAIT: begin
            if (!(read || write)) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else begin
               dec = 1'b1;
               if (expired) begin
                  state_d = DONE;
                  rd_load = 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign commit      = (state_q == DONE) && we_q && in_range;
   assign waitrequest = (read || write) && (state_q != DONE);
   assign readdata    = rdata_q;
   assign err         = err_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         we_q    <= we_d;
         err_q   <= err_d;
         if (rd_load) rdata_q <= in_range ? mem_q[mem_idx] : '0;
      end
   end

   // Array is deliberately outside reset so contents survive it.
   always_ff @(posedge clk) begin
      if (commit) begin
         for (int i = 0; i < 4; i++) begin
            if (be_q[i]) mem_q[mem_idx][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_avalon_ram.sv
// tb/tb_avalon_ram.sv - self-checking bench for avalon_ram (zero and three wait-state instances)
module tb_avalon_ram;

   localparam logic [31:0] BASE = 32'hBFC00000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] bus_addr  [2];
   logic        bus_rd    [2];
   logic        bus_wr    [2];
   logic [31:0] bus_wdata [2];
   logic [3:0]  bus_be    [2];
   logic        bus_wreq  [2];
   logic [31:0] bus_rdata [2];
   logic        bus_err   [2];

   int n_checks;
   int n_fail;

   logic [31:0] ref_mem [2][16];
   logic        ref_err [2];

   always #5 clk = ~clk;

   avalon_ram #(
      .BASE_ADDR   (BASE),
      .DEPTH_WORDS (1024),
      .WAIT_CYCLES (0),
      .INIT_FILE   ("")
   ) u_dut0 (
      .clk         (clk),
      .reset       (reset_n),
      .address     (bus_addr[0]),
      .read        (bus_rd[0]),
      .write       (bus_wr[0]),
      .writedata   (bus_wdata[0]),
      .byteenable  (bus_be[0]),
      .waitrequest (bus_wreq[0]),
      .readdata    (bus_rdata[0]),
      .err         (bus_err[0])
   );

   avalon_ram #(
      .BASE_ADDR   (BASE),
      .DEPTH_WORDS (1024),
      .WAIT_CYCLES (3),
      .INIT_FILE   ("")
   ) u_dut3 (
      .clk         (clk),
      .reset       (reset_n),
      .address     (bus_addr[1]),
      .read        (bus_rd[1]),
      .write       (bus_wr[1]),
      .writedata   (bus_wdata[1]),
      .byteenable  (bus_be[1]),
      .waitrequest (bus_wreq[1]),
      .readdata    (bus_rdata[1]),
      .err         (bus_err[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One complete Avalon access; returns readdata and the number of cycles waitrequest was high.
   task automatic access(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, output logic [31:0] rd, output int hi);
      int guard;
      guard        = 0;
      hi           = 0;
      bus_addr[d]  = a;
      bus_wdata[d] = wd;
      bus_be[d]    = be;
      bus_rd[d]    = !wr;
      bus_wr[d]    = wr;
      @(negedge clk);
      while (bus_wreq[d] && guard < 40) begin
         hi++;
         guard++;
         @(negedge clk);
      end
      check("access_timeout", bus_wreq[d], 1'b0);
      rd = bus_rdata[d];
      @(posedge clk);
      #1;
      bus_rd[d] = 1'b0;
      bus_wr[d] = 1'b0;
   endtask

   task automatic check_wait(input int d, input int hi, input string tag);
`ifdef AVALON_RAM_RANDOM_WAIT_EN
      check(tag, (hi >= 1 && hi <= 8), 1'b1);
`else
      check(tag, hi, (d == 0) ? 1 : 4);
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      ref_err[0] = 1'b0;
      ref_err[1] = 1'b0;
   endtask

   task automatic random_op(input int d);
      int          w, kind;
      bit          wr;
      logic [3:0]  be;
      logic [31:0] wd, a, idx, rd, exp_word;
      bit          inr, mis;
      int          hi;
      w    = $urandom_range(0, 15);
      kind = $urandom_range(0, 9);
      wr   = 1'($urandom_range(0, 1));
      be   = 4'($urandom_range(0, 15));
      wd   = $urandom;
      case (kind)
         0:       a = BASE + 32'h1000 + 4 * $urandom_range(0, 255);
         1:       a = BASE - 4 * (1 + $urandom_range(0, 3));
         2:       a = BASE + 4 * w + $urandom_range(1, 3);
         default: a = BASE + 4 * w;
      endcase
      idx = (a - BASE) >> 2;
      inr = (idx < 1024);
      mis = (a[1:0] != 2'b00);
      if (!inr || mis) ref_err[d] = 1'b1;
      access(d, wr, a, wd, be, rd, hi);
      check_wait(d, hi, "rand_wait");
      if (wr) begin
         if (inr) begin
            exp_word = ref_mem[d][idx[3:0]];
            for (int i = 0; i < 4; i++)
               if (be[i]) exp_word[8*i +: 8] = wd[8*i +: 8];
            ref_mem[d][idx[3:0]] = exp_word;
         end
      end else begin
         check("rand_rdata", rd, inr ? ref_mem[d][idx[3:0]] : 32'h0);
      end
      check("rand_err", bus_err[d], ref_err[d]);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      int          hi;
      n_checks = 0;
      n_fail   = 0;
      reset_n  = 1'b0;
      for (int d = 0; d < 2; d++) begin
         bus_addr[d]  = '0;
         bus_rd[d]    = 1'b0;
         bus_wr[d]    = 1'b0;
         bus_wdata[d] = '0;
         bus_be[d]    = '0;
         ref_err[d]   = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check("reset_rdata", bus_rdata[d], 32'h0);
         check("reset_err", bus_err[d], 1'b0);
         check("reset_wreq", bus_wreq[d], 1'b0);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Full-word write then read, zero wait states.
      access(0, 1'b1, BASE, 32'h11223344, 4'hF, rd, hi);
      check_wait(0, hi, "w0_wr_wait");
      access(0, 1'b0, BASE, 32'h0, 4'hF, rd, hi);
      check_wait(0, hi, "w0_rd_wait");
      check("w0_rdata", rd, 32'h11223344);
      check("w0_err", bus_err[0], 1'b0);

      // Partial write, three wait states.
      access(1, 1'b1, BASE, 32'h11223344, 4'hF, rd, hi);
      check_wait(1, hi, "w3_wr_wait");
      access(1, 1'b1, BASE, 32'hAABBCCDD, 4'b0101, rd, hi);
      check_wait(1, hi, "w3_partial_wait");
      access(1, 1'b0, BASE, 32'h0, 4'hF, rd, hi);
      check("w3_partial_rdata", rd, 32'h11BB33DD);

      // read and write together: ignored, err set, waitrequest held.
      bus_addr[0] = BASE;
      bus_rd[0]   = 1'b1;
      bus_wr[0]   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rw_wreq", bus_wreq[0], 1'b1);
      end
      check("rw_err", bus_err[0], 1'b1);
      @(posedge clk);
      #1;
      bus_rd[0] = 1'b0;
      bus_wr[0] = 1'b0;
      access(0, 1'b0, BASE, 32'h0, 4'hF, rd, hi);
      check("rw_ignored", rd, 32'h11223344);

      // Misaligned write goes to word 0.
      access(0, 1'b1, BASE + 32'h2, 32'h55667788, 4'hF, rd, hi);
      access(0, 1'b0, BASE, 32'h0, 4'hF, rd, hi);
      check("misalign_rdata", rd, 32'h55667788);
      check("misalign_err", bus_err[0], 1'b1);

      // Out of range read: index 1024.
      check("oor_err_pre", bus_err[1], 1'b0);
      access(1, 1'b0, BASE + 32'h1000, 32'h0, 4'hF, rd, hi);
      check("oor_rdata", rd, 32'h0);
      check("oor_err", bus_err[1], 1'b1);

`ifndef AVALON_RAM_RANDOM_WAIT_EN
      // Reset while a write is in WAIT.
      access(1, 1'b1, BASE + 32'h14, 32'h00000005, 4'hF, rd, hi);
      access(1, 1'b0, BASE + 32'h14, 32'h0, 4'hF, rd, hi);
      check("rst_old_word", rd, 32'h00000005);
      bus_addr[1]  = BASE + 32'h14;
      bus_wdata[1] = 32'hDEADBEEF;
      bus_be[1]    = 4'hF;
      bus_wr[1]    = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("rst_rdata", bus_rdata[1], 32'h0);
      check("rst_err", bus_err[1], 1'b0);
      bus_wr[1] = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      access(1, 1'b0, BASE + 32'h14, 32'h0, 4'hF, rd, hi);
      check("rst_discard", rd, 32'h00000005);
      check("rst_err_after", bus_err[1], 1'b0);

      // Master abandons a write during WAIT.
      access(1, 1'b1, BASE + 32'h18, 32'h66666666, 4'hF, rd, hi);
      bus_addr[1]  = BASE + 32'h18;
      bus_wdata[1] = 32'h12345678;
      bus_wr[1]    = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus_wr[1] = 1'b0;
      @(posedge clk);
      #1;
      check("abandon_err", bus_err[1], 1'b1);
      access(1, 1'b0, BASE + 32'h18, 32'h0, 4'hF, rd, hi);
      check("abandon_nowrite", rd, 32'h66666666);
`endif

      // Randomized traffic against the reference model.
      do_reset();
      for (int d = 0; d < 2; d++) begin
         for (int w = 0; w < 16; w++) begin
            ref_mem[d][w] = $urandom;
            access(d, 1'b1, BASE + 4 * w, ref_mem[d][w], 4'hF, rd, hi);
         end
         for (int n = 0; n < 60; n++) random_op(d);
      end

`ifdef AVALON_RAM_RANDOM_WAIT_EN
      begin
         int hi_run1 [100];
         do_reset();
         for (int i = 0; i < 100; i++) begin
            access(0, 1'b0, BASE + 4 * (i % 16), 32'h0, 4'hF, rd, hi_run1[i]);
            check_wait(0, hi_run1[i], "lfsr_range");
            check("lfsr_rdata1", rd, ref_mem[0][i % 16]);
         end
         do_reset();
         for (int i = 0; i < 100; i++) begin
            access(0, 1'b0, BASE + 4 * (i % 16), 32'h0, 4'hF, rd, hi);
            check("lfsr_repeat", hi, hi_run1[i]);
            check("lfsr_rdata2", rd, ref_mem[0][i % 16]);
         end
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/avalon_ram.md
AVALON_RAM -- requirements
Module: avalon_ram

Interface
REQ-001 Parameters SHALL be:
- BASE_ADDR, 32'hBFC00000, byte address of word 0.
- DEPTH_WORDS, 1024, number of 32-bit words.
- WAIT_CYCLES, 1, fixed wait states per access (0..15).
- INIT_FILE, "", hex image loaded at elaboration when non-empty.

REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- address  in  32  Avalon byte address from the CPU master.
- read  in  1  read request.
- write  in  1  write request.
- writedata  in  32  write data, bus (little-endian) byte order.
- byteenable  in  4  byte lanes; bit i qualifies writedata[8i+7:8i].
- waitrequest  out  1  slave not ready; master holds request while high.
- readdata  out  32  read data, valid when read=1 and waitrequest=0.
- err  out  1  sticky protocol or decode error flag.

Function
REQ-003 FSM states SHALL be IDLE, WAIT, DONE.
REQ-004 In IDLE with read^write=1, the block SHALL latch address, writedata, byteenable and direction, and load the wait counter with the wait count.
- Next state: WAIT if the count is greater than 0, else DONE.
REQ-005 WAIT SHALL decrement the counter each cycle and go to DONE when the counter reaches 1.
REQ-006 DONE SHALL go unconditionally to IDLE.
REQ-007 waitrequest SHALL be combinational: (read|write) AND state!=DONE.
- An access therefore spans wait+2 cycles, with waitrequest low only in the DONE cycle.
REQ-008 readdata SHALL be registered.
- Loaded with mem[index] on entry to DONE; held otherwise.
- Reads a word written in the immediately preceding access with the new value.
REQ-009 A write SHALL commit at the rising edge leaving DONE.
- Only lanes with byteenable[i]=1 are updated; byteenable=0000 leaves memory unchanged.
REQ-010 Index SHALL be (address-BASE_ADDR)>>2, computed modulo 2^32.
- The address is in range iff the index is less than DEPTH_WORDS.
REQ-011 Out-of-range access SHALL complete normally with readdata=0, no write, and err set.
REQ-012 address[1:0]!=0 SHALL be decoded as the aligned word and SHALL set err.
REQ-013 read=1 and write=1 in IDLE SHALL set err and be ignored.
- No transaction starts, and waitrequest stays high.
REQ-014 If read and write both drop while in WAIT, the block SHALL return to IDLE with no memory update.
- The master has abandoned the request (protocol violation); err is set.
REQ-015 err SHALL be cleared only by reset.

Reset
REQ-016 Reset assertion SHALL act immediately, independent of clk.
- state=IDLE, counter=0, readdata=0, err=0.
- waitrequest then follows REQ-007.
REQ-017 Reset mid-transaction SHALL discard the pending access; memory is unchanged.
REQ-018 Memory contents SHALL NOT be reset.
- Contents are INIT_FILE, or X when INIT_FILE is empty.

Configuration
REQ-019 Macro AVALON_RAM_RANDOM_WAIT_EN SHALL control how the wait count is chosen.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances once per accepted access, and its low 3 bits (0..7) give that access's wait count; WAIT_CYCLES is ignored.
- Undefined: the wait count is WAIT_CYCLES, and no LFSR exists.

Structure
REQ-020 Shared package codes SHALL hold the following, reused by the CPU's future waitrequest stall logic:
- typedef avalon_ram_state_t (IDLE, WAIT, DONE).
- Constant RAM_LFSR_SEED.
- Existing size_t for the data/address types.
REQ-021 Sub-module avalon_ram_wait_gen SHALL own the wait counter and the optional LFSR.
- Outputs: wait count and counter-expired flag.
REQ-022 The memory array and FSM SHALL remain in avalon_ram.

Verification
REQ-023 Bench SHALL cover:
- Single-cycle access: WAIT_CYCLES=0, write 0x11223344 to 0xBFC00000 with be=1111, then read it. Response: each access has waitrequest high for 1 cycle, and readdata=0x11223344.
- Partial write: WAIT_CYCLES=3, write 0xAABBCCDD with be=0101 over word 0x11223344. Response: waitrequest high for 4 cycles, and a later read returns 0x11BB33DD.
- Out of range: read 0xBFC01000 (index 1024). Response: completes, readdata=0x00000000, err=1.
- Protocol errors: read=write=1 gives err=1 with waitrequest held high. A write to 0xBFC00002 writes word 0 and sets err.
- Reset mid-write: reset low during WAIT of a write of 0xDEADBEEF to word 5 (old 0x00000005). Response: a following read returns 0x00000005, err=0, readdata=0 during reset.
- With AVALON_RAM_RANDOM_WAIT_EN: 100 back-to-back reads. Response: every wait count is in 0..7, the sequence is identical across two runs after reset, and data is correct.
